// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall bundle: ID/EX/MEM hazard fields in, pipeline-register controls out.
// master drives the hazard fields (core side); slave is the hazard_stall_unit. Optional HAZARD_STATS_EN adds stats_clr/stall_cycles.
interface hazard_stall_unit_if #(
    parameter int REG_W = 3
);
    logic [REG_W-1:0] Rsrc1_id;
    logic [REG_W-1:0] Rsrc2_id;
    logic             use1_id;
    logic             use2_id;
    logic [REG_W-1:0] Rdst_ex;
    logic             WB_ex;
    logic             MR_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken_ex;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             exmem_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic             mem_timeout;
`ifdef HAZARD_STATS_EN
    logic             stats_clr;
    logic [15:0]      stall_cycles;

    modport master (
        output Rsrc1_id, Rsrc2_id, use1_id, use2_id, Rdst_ex,
        output WB_ex, MR_ex, mem_req, mem_ready, branch_taken_ex,
        output stats_clr,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_bubble, memwb_bubble, mem_timeout,
        input  stall_cycles
    );
    modport slave (
        input  Rsrc1_id, Rsrc2_id, use1_id, use2_id, Rdst_ex,
        input  WB_ex, MR_ex, mem_req, mem_ready, branch_taken_ex,
        input  stats_clr,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_bubble, memwb_bubble, mem_timeout,
        output stall_cycles
    );
`else
    modport master (
        output Rsrc1_id, Rsrc2_id, use1_id, use2_id, Rdst_ex,
        output WB_ex, MR_ex, mem_req, mem_ready, branch_taken_ex,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_bubble, memwb_bubble, mem_timeout
    );
    modport slave (
        input  Rsrc1_id, Rsrc2_id, use1_id, use2_id, Rdst_ex,
        input  WB_ex, MR_ex, mem_req, mem_ready, branch_taken_ex,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_bubble, memwb_bubble, mem_timeout
    );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: load-use stall+bubble, multi-cycle memory freeze, taken-branch flush.
// Ports: clk, rst (async active-low), hz (slave bundle). Macro HAZARD_STATS_EN adds a stall-cycle counter.
module hazard_stall_unit #(
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_unit_if.slave hz
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, MEM_WAIT} state_e;

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       tmo_q, tmo_d;
    logic       lu, mh, freeze;

    always_comb begin
        lu = hz.MR_ex & hz.WB_ex &
             ((hz.use1_id & (hz.Rsrc1_id == hz.Rdst_ex)) |
              (hz.use2_id & (hz.Rsrc2_id == hz.Rdst_ex)));
        mh = hz.mem_req & ~hz.mem_ready;
        freeze = (state_q == MEM_WAIT) | mh;
    end

    // Outputs are gated by rst so they drop the instant reset asserts,
    // even while mem_req is still high.
    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.ifid_stall   = 1'b0;
        hz.idex_stall   = 1'b0;
        hz.exmem_stall  = 1'b0;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.memwb_bubble = 1'b0;
        if (rst) begin
            priority case (1'b1)
                freeze: begin
                    hz.pc_stall     = 1'b1;
                    hz.ifid_stall   = 1'b1;
                    hz.idex_stall   = 1'b1;
                    hz.exmem_stall  = 1'b1;
                    hz.memwb_bubble = 1'b1;
                end
                hz.branch_taken_ex: begin
                    hz.ifid_flush  = 1'b1;
                    hz.idex_bubble = 1'b1;
                end
                lu: begin
                    hz.pc_stall    = 1'b1;
                    hz.ifid_stall  = 1'b1;
                    hz.idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.mem_timeout = tmo_q;

    // A dropped mem_req in MEM_WAIT is an abort and releases like mem_ready.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (mh) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_req || hz.mem_ready) begin
                    state_d = IDLE;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q != 8'hFF) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = 8'd0;
            end
        endcase
        if (state_d == MEM_WAIT && wcnt_d == TMO) tmo_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (hz.stats_clr)
            stall_d = 16'd0;
        else if (hz.pc_stall && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= 16'd0;
        else      stall_q <= stall_d;
    end

    assign hz.stall_cycles = stall_q;
`endif
endmodule
